// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, control-word bit indices and state/class encodings
package cpu_ctrl_pkg;

  localparam int CTRL_W = 39;
  localparam int ALU_W  = 13;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  // Bus sources 0..8, strobes 9..20, register select 21..25, ALU ops 26..38
  localparam int C_COUT = 0, C_HIOUT = 1, C_LOOUT = 2, C_ZHIGHOUT = 3, C_ZLOWOUT = 4;
  localparam int C_PCOUT = 5, C_MDROUT = 6, C_BAOUT = 7, C_INPORTOUT = 8;
  localparam int C_READ = 9, C_WRITE = 10, C_PCIN = 11, C_IRIN = 12, C_MARIN = 13, C_YIN = 14;
  localparam int C_HIIN = 15, C_LOIN = 16, C_ZIN = 17, C_MDRIN = 18, C_CONIN = 19, C_OUTPORT = 20;
  localparam int C_GRA = 21, C_GRB = 22, C_GRC = 23, C_RIN = 24, C_ROUT = 25;
  localparam int C_AND = 26, C_OR = 27, C_ADD = 28, C_SUB = 29, C_MUL = 30, C_DIV = 31;
  localparam int C_SHR = 32, C_SHL = 33, C_ROR = 34, C_ROL = 35, C_NEG = 36, C_NOT = 37;
  localparam int C_INCPC = 38;

  typedef enum logic [3:0] {
    S_RST, S_IDLE, S_F0, S_F1, S_F2, S_F3, S_E1, S_E2, S_E3, S_E4, S_E5, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU3, CLS_IMM, CLS_LD, CLS_LDI, CLS_ST, CLS_MULDIV, CLS_UNARY, CLS_BR,
    CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } cls_e;

  function automatic logic [CTRL_W-1:0] cb(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

  function automatic logic [ALU_W-1:0] alu_sel(input int idx);
    return ALU_W'(1) << (idx - C_AND);
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - maps the 5-bit opcode to an instruction class and one-hot ALU op
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]       opcode_i,
  output cls_e             cls_o,
  output logic [ALU_W-1:0] alu_op_o
);

  always_comb begin
    cls_o    = CLS_NOP;
    alu_op_o = '0;
    case (opcode_i)
      OP_LD:   cls_o = CLS_LD;
      OP_LDI:  cls_o = CLS_LDI;
      OP_ST:   cls_o = CLS_ST;
      OP_ADD:  begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_ADD); end
      OP_SUB:  begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_SUB); end
      OP_AND:  begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_AND); end
      OP_OR:   begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_OR);  end
      OP_SHR:  begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_SHR); end
      OP_SHL:  begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_SHL); end
      OP_ROR:  begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_ROR); end
      OP_ROL:  begin cls_o = CLS_ALU3;   alu_op_o = alu_sel(C_ROL); end
      OP_ADDI: begin cls_o = CLS_IMM;    alu_op_o = alu_sel(C_ADD); end
      OP_ANDI: begin cls_o = CLS_IMM;    alu_op_o = alu_sel(C_AND); end
      OP_ORI:  begin cls_o = CLS_IMM;    alu_op_o = alu_sel(C_OR);  end
      OP_MUL:  begin cls_o = CLS_MULDIV; alu_op_o = alu_sel(C_MUL); end
      OP_DIV:  begin cls_o = CLS_MULDIV; alu_op_o = alu_sel(C_DIV); end
      OP_NEG:  begin cls_o = CLS_UNARY;  alu_op_o = alu_sel(C_NEG); end
      OP_NOT:  begin cls_o = CLS_UNARY;  alu_op_o = alu_sel(C_NOT); end
      OP_BR:   cls_o = CLS_BR;
      OP_JR:   cls_o = CLS_JR;
      OP_IN:   cls_o = CLS_IN;
      OP_OUT:  cls_o = CLS_OUT;
      OP_MFHI: cls_o = CLS_MFHI;
      OP_MFLO: cls_o = CLS_MFLO;
      OP_HALT: cls_o = CLS_HALT;
      default: cls_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute sequencer driving the single-bus datapath
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic [31:0]       ir,
  input  logic              con_ff,
  input  logic              mem_rdy,
  input  logic              stop,
  output logic [CTRL_W-1:0] ctrl,
  output logic              run
);

  state_e           state_q, state_d;
  cls_e             cls;
  logic [ALU_W-1:0] alu_op;
  logic [2:0]       n_steps;
  state_e           fin;
  logic             unused_ir_bits;

  assign unused_ir_bits = ^ir[26:0];

  opcode_decode u_dec (
    .opcode_i (ir[31:27]),
    .cls_o    (cls),
    .alu_op_o (alu_op)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    case (cls)
      CLS_ALU3, CLS_IMM, CLS_LDI: n_steps = 3'd3;
      CLS_LD, CLS_ST:             n_steps = 3'd5;
      CLS_MULDIV, CLS_BR:         n_steps = 3'd4;
      CLS_UNARY:                  n_steps = 3'd2;
      default:                    n_steps = 3'd1;
    endcase
  end

  // stop only matters on the step that would otherwise lead into F0
  assign fin = stop ? S_IDLE : S_F0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST, S_IDLE: state_d = fin;
      S_F0:          state_d = S_F1;
      S_F1:          state_d = S_F2;
      S_F2:          state_d = mem_rdy ? S_F3 : S_F2;
      S_F3: begin
        if (cls == CLS_HALT)     state_d = S_HALT;
        else if (cls == CLS_NOP) state_d = fin;
        else                     state_d = S_E1;
      end
      S_E1: state_d = (n_steps == 3'd1) ? fin : S_E2;
      S_E2: state_d = (n_steps == 3'd2) ? fin : S_E3;
      S_E3: state_d = (n_steps == 3'd3) ? fin : S_E4;
      S_E4: begin
        if (cls == CLS_LD && !mem_rdy) state_d = S_E4;
        else                           state_d = (n_steps == 3'd4) ? fin : S_E5;
      end
      S_E5:   state_d = (cls == CLS_ST && !mem_rdy) ? S_E5 : fin;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_F0: ctrl = cb(C_PCOUT) | cb(C_MARIN) | cb(C_INCPC) | cb(C_ZIN);
      S_F1: ctrl = cb(C_ZLOWOUT) | cb(C_PCIN);
      S_F2: ctrl = cb(C_READ) | cb(C_MDRIN);
      S_F3: ctrl = cb(C_MDROUT) | cb(C_IRIN);
      S_E1: case (cls)
        CLS_ALU3, CLS_IMM:        ctrl = cb(C_GRB) | cb(C_ROUT) | cb(C_YIN);
        CLS_LD, CLS_LDI, CLS_ST:  ctrl = cb(C_GRB) | cb(C_BAOUT) | cb(C_YIN);
        CLS_MULDIV:               ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_YIN);
        CLS_UNARY: begin
          ctrl = cb(C_GRB) | cb(C_ROUT) | cb(C_ZIN);
          ctrl[C_AND +: ALU_W] = alu_op;
        end
        CLS_BR:   ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_CONIN);
        CLS_JR:   ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_PCIN);
        CLS_IN:   ctrl = cb(C_INPORTOUT) | cb(C_GRA) | cb(C_RIN);
        CLS_OUT:  ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_OUTPORT);
        CLS_MFHI: ctrl = cb(C_HIOUT) | cb(C_GRA) | cb(C_RIN);
        CLS_MFLO: ctrl = cb(C_LOOUT) | cb(C_GRA) | cb(C_RIN);
        default:  ctrl = '0;
      endcase
      S_E2: case (cls)
        CLS_ALU3, CLS_IMM, CLS_MULDIV: begin
          ctrl = (cls == CLS_IMM) ? cb(C_COUT) | cb(C_ZIN)
               : cb((cls == CLS_ALU3) ? C_GRC : C_GRB) | cb(C_ROUT) | cb(C_ZIN);
          ctrl[C_AND +: ALU_W] = alu_op;
        end
        CLS_LD, CLS_LDI, CLS_ST: ctrl = cb(C_COUT) | cb(C_ADD) | cb(C_ZIN);
        CLS_UNARY:               ctrl = cb(C_ZLOWOUT) | cb(C_GRA) | cb(C_RIN);
        CLS_BR:                  ctrl = cb(C_PCOUT) | cb(C_YIN);
        default:                 ctrl = '0;
      endcase
      S_E3: case (cls)
        CLS_ALU3, CLS_IMM, CLS_LDI: ctrl = cb(C_ZLOWOUT) | cb(C_GRA) | cb(C_RIN);
        CLS_LD, CLS_ST:             ctrl = cb(C_ZLOWOUT) | cb(C_MARIN);
        CLS_MULDIV:                 ctrl = cb(C_ZLOWOUT) | cb(C_LOIN);
        CLS_BR:                     ctrl = cb(C_COUT) | cb(C_ADD) | cb(C_ZIN);
        default:                    ctrl = '0;
      endcase
      S_E4: case (cls)
        CLS_LD:     ctrl = cb(C_READ) | cb(C_MDRIN);
        CLS_ST:     ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_MDRIN);
        CLS_MULDIV: ctrl = cb(C_ZHIGHOUT) | cb(C_HIIN);
        CLS_BR:     ctrl = con_ff ? (cb(C_ZLOWOUT) | cb(C_PCIN)) : '0;
        default:    ctrl = '0;
      endcase
      S_E5: case (cls)
        CLS_LD:  ctrl = cb(C_MDROUT) | cb(C_GRA) | cb(C_RIN);
        CLS_ST:  ctrl = cb(C_WRITE);
        default: ctrl = '0;
      endcase
      default: ctrl = '0;
    endcase
  end

  assign run = !(state_q inside {S_RST, S_IDLE, S_HALT});

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the 32-bit single-bus CPU datapath. It fetches each instruction over the shared bus, decodes IR[31:27] and drives the datapath's register-enable, bus-select, ALU-op and memory strobes one micro-step per clock. It stretches memory steps with a ready handshake and evaluates conditional branches from the CON flip-flop. It replaces the bench-driven control inputs of the datapath top level.

## Interface
- No parameters; opcode values, control-word bit indices and state codes come from `cpu_ctrl_pkg`.
- `clk` in 1: single system clock, rising edge.
- `clear` in 1: reset, asynchronous, active-high.
- `ir` in 32: IR register contents. opcode = ir[31:27].
- `con_ff` in 1: branch condition flip-flop output.
- `mem_rdy` in 1: memory has completed the current read/write this cycle.
- `stop` in 1: level; when 1, hold before the next fetch.
- `ctrl` out 39: packed control word, one bit per datapath control.
  - Bus sources: Cout, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, BAout, Inportout.
  - Register and memory strobes: read, write, PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, CONin, OutPort.
  - Register select: Gra, Grb, Grc, Rin, Rout.
  - ALU ops: AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC.
- `run` out 1: 1 while executing; 0 in reset, stopped or halted.

## Operation
- `ctrl` is a Moore decode of state, plus ir and con_ff. At most one bus-source bit and at most one ALU-op bit are high in any cycle.
- Fetch sequence:
  - F0: PCout MARin IncPC Zin.
  - F1: Zlowout PCin.
  - F2: read MDRin; repeats until mem_rdy.
  - F3: MDRout IRin.
- Execute steps E1..E5, per opcode:
  - add/sub/and/or/shr/shl/ror/rol (00011–01010):
    - E1: Grb Rout Yin.
    - E2: Grc Rout op Zin.
    - E3: Zlowout Gra Rin.
  - addi/andi/ori (01011–01101): same as above, but E2 = Cout op Zin.
  - ld (00000):
    - E1: Grb BAout Yin.
    - E2: Cout ADD Zin.
    - E3: Zlowout MARin.
    - E4: read MDRin, waits on mem_rdy.
    - E5: MDRout Gra Rin.
  - ldi (00001): E1–E2 as ld; E3 = Zlowout Gra Rin.
  - st (00010): E1–E3 as ld, then:
    - E4: Gra Rout MDRin.
    - E5: write, waits on mem_rdy.
  - mul/div (01110/01111):
    - E1: Gra Rout Yin.
    - E2: Grb Rout op Zin.
    - E3: Zlowout LOin.
    - E4: Zhighout HIin.
  - neg/not (10000/10001):
    - E1: Grb Rout op Zin.
    - E2: Zlowout Gra Rin.
  - br (10010):
    - E1: Gra Rout CONin.
    - E2: PCout Yin.
    - E3: Cout ADD Zin.
    - E4: Zlowout PCin only if con_ff=1; otherwise all-zero.
  - jr (10011), E1: Gra Rout PCin.
  - in (10101), E1: Inportout Gra Rin.
  - out (10110), E1: Gra Rout OutPort.
  - mfhi (10111), E1: HIout Gra Rin.
  - mflo (11000), E1: LOout Gra Rin.
  - nop (11001), jal (10100) and 11011–11111: no execute step; return to F0.
  - halt (11010): enter HALT.
- Wait states re-assert the same strobes (idempotent). Rewrites of MDR during a wait are harmless; the last write is on the mem_rdy cycle.

## Timing
- `clear` asserted: state RST, ctrl=0, run=0 immediately (asynchronous). An in-progress read/write is abandoned.
- After `clear` deasserts: RST→F0 on the next edge; run=1 from F0 onward.
- `stop` is sampled only in the state preceding F0, i.e. at the last step of an instruction or in RST:
  - stop=1: go to IDLE (ctrl=0, run=0); stay until stop=0, then F0.
- Latency with mem_rdy already high:
  - Fetch: 4 cycles.
  - R-type/immediate/ldi: 7.
  - ld/st/br/mul/div: 8–9.
  - Single-step ops: 5.
  - Each low mem_rdy cycle in F2/E4(ld)/E5(st) adds one cycle.
- HALT: ctrl=0, run=0; left only by clear. stop is ignored in HALT.
- con_ff is evaluated combinationally in br E4. CONin in E1 guarantees it is settled by then.

## Structure
- `cpu_ctrl_pkg` holds:
  - Opcode localparams.
  - ctrl bit-index localparams, shared with the datapath top so the 39 bits fan out by name.
  - State encoding: RST, IDLE, F0–F3, E1–E5, HALT.
- One sub-module, `opcode_decode`: maps ir[31:27] to an instruction class (ALU3, IMM, LD, LDI, ST, MULDIV, UNARY, BR, JR, IN, OUT, MFHI, MFLO, NOP, HALT) plus a one-hot ALU-op field.
- `control_unit` holds:
  - The state register and step sequencing.
  - Wait logic.
  - ctrl decode.

## Test plan
- Reset: clear=1 mid-F2 with read=1 → ctrl=0 and run=0 the same cycle; 1 cycle after release, F0 drives PCout MARin IncPC Zin.
- add r5,r2,r4 (ir=0x1A920000), mem_rdy tied 1 → exactly 7 cycles F0..E3; E2 asserts Grc Rout ADD Zin; E3 asserts Zlowout Gra Rin; then F0.
- ld r1,0x10(r2) (ir=0x00900010), mem_rdy low 3 cycles in E4 → read MDRin held 4 cycles; MDRout Gra Rin on the cycle after mem_rdy; total 12 cycles.
- br with con_ff=0 vs 1 → E4 ctrl=0 vs Zlowout PCin; both return to F0.
- mul r3,r1 → E3 Zlowout LOin, E4 Zhighout HIin, never Rin.
- halt (ir=0xD0000000), then stop toggled → run=0, ctrl=0 indefinitely; clear pulse restarts fetch.
